axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: merges two AXI-Stream packet sources onto one output with
// packet-level round-robin arbitration. Packets never interleave; one idle
// arbitration cycle separates consecutive packets. The output is one register
// stage, so an accepted input beat appears on m_axis_* one cycle later.
//
// Optional feature: define AXIS_ARB_PKT_CNT_EN to add 32-bit wrapping packet
// counters pkt_cnt_0 / pkt_cnt_1 (count of accepted beats with tlast=1).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet in flight; pick a source from the current tvalids
// GNT0  | port 0 owns the output until its tlast beat is accepted
// GNT1  | port 1 owns the output until its tlast beat is accepted

module axis_rr_arbiter #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              axis_aclk,
    input  logic              axis_aresetn,

    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tkeep,

    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tlast,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tkeep,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tid,

    output logic [1:0]        arb_gnt
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [31:0]       pkt_cnt_0,
    output logic [31:0]       pkt_cnt_1
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_gnt;
    logic       out_free;
    logic       acc0;
    logic       acc1;

    // The output register can take a beat when empty or draining this cycle.
    assign out_free       = !m_axis_tvalid || m_axis_tready;
    assign s0_axis_tready = (state == GNT0) && out_free;
    assign s1_axis_tready = (state == GNT1) && out_free;
    assign acc0           = s0_axis_tvalid && s0_axis_tready;
    assign acc1           = s1_axis_tvalid && s1_axis_tready;
    assign arb_gnt        = {state == GNT1, state == GNT0};

    // Next-state: arbitrate only in IDLE; release grant on the tlast beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    state_nxt = last_gnt ? GNT0 : GNT1;
                end else if (s0_axis_tvalid) begin
                    state_nxt = GNT0;
                end else if (s1_axis_tvalid) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin history (reset to 1 so port 0 wins first tie).
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state == IDLE && state_nxt == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    // Output register: load on accept (also when draining), else clear on handshake.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
        end else if (acc0) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s0_axis_tlast;
            m_axis_tid    <= 1'b0;
            m_axis_tdata  <= s0_axis_tdata;
            m_axis_tkeep  <= s0_axis_tkeep;
        end else if (acc1) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s1_axis_tlast;
            m_axis_tid    <= 1'b1;
            m_axis_tdata  <= s1_axis_tdata;
            m_axis_tkeep  <= s1_axis_tkeep;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    // Per-port completed-packet counters, wrapping at 2^32.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            pkt_cnt_0 <= '0;
            pkt_cnt_1 <= '0;
        end else begin
            if (acc0 && s0_axis_tlast) begin
                pkt_cnt_0 <= pkt_cnt_0 + 32'd1;
            end
            if (acc1 && s1_axis_tlast) begin
                pkt_cnt_1 <= pkt_cnt_1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter. Sources generate packets of random
// length; a cycle-level reference built from the arbitration and handshake
// rules predicts grants, treadys and the output register every cycle.
module tb_axis_rr_arbiter;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;

    logic              axis_aclk = 1'b0;
    logic              axis_aresetn = 1'b0;
    logic              s0_axis_tvalid = 1'b0, s0_axis_tlast = 1'b0;
    logic              s1_axis_tvalid = 1'b0, s1_axis_tlast = 1'b0;
    logic [DATA_W-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
    logic [KEEP_W-1:0] s0_axis_tkeep = '0, s1_axis_tkeep = '0;
    logic              s0_axis_tready, s1_axis_tready;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tid;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [KEEP_W-1:0] m_axis_tkeep;
    logic [1:0]        arb_gnt;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [31:0]       pkt_cnt_0, pkt_cnt_1;
`endif

    axis_rr_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
        .axis_aclk      (axis_aclk),
        .axis_aresetn   (axis_aresetn),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tid     (m_axis_tid),
        .arb_gnt        (arb_gnt)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt_0      (pkt_cnt_0),
        .pkt_cnt_1      (pkt_cnt_1)
`endif
    );

    always #5 axis_aclk = ~axis_aclk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // source generators
    logic [DATA_W-1:0] src_data [2];
    logic [KEEP_W-1:0] src_keep [2];
    logic              src_last [2];
    logic              src_v    [2];
    logic              src_have [2];
    int                rem      [2];
    int                len_lo   [2];
    int                len_hi   [2];
    logic              port_en  [2];
    int                acc_beats[2];
    int                pvalid = 100;
    int                pready = 100;

    // reference model
    int                own;
    logic              last_g;
    logic              exp_mv, exp_ml, exp_mid;
    logic [DATA_W-1:0] exp_md;
    logic [KEEP_W-1:0] exp_mk;
    int                exp_pkts[2];
    int                grant_log[$];
    int                obs_beats;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own = -1;
        last_g = 1'b1;
        exp_mv = 1'b0; exp_ml = 1'b0; exp_mid = 1'b0;
        exp_md = '0; exp_mk = '0;
        grant_log.delete();
        for (int p = 0; p < 2; p++) begin
            src_v[p] = 1'b0; src_have[p] = 1'b0; rem[p] = 0;
            acc_beats[p] = 0; exp_pkts[p] = 0;
        end
    endtask

    task automatic drive_pins();
        s0_axis_tvalid = src_v[0]; s0_axis_tdata = src_data[0];
        s0_axis_tkeep  = src_keep[0]; s0_axis_tlast = src_last[0];
        s1_axis_tvalid = src_v[1]; s1_axis_tdata = src_data[1];
        s1_axis_tkeep  = src_keep[1]; s1_axis_tlast = src_last[1];
    endtask

    // Assert reset between edges, check values at once, release on a negedge.
    task automatic do_reset();
        #1;
        axis_aresetn = 1'b0;
        model_reset();
        drive_pins();
        m_axis_tready = 1'b0;
        #1;
        check_val("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check_val("rst_m_tid",    64'(m_axis_tid),    64'd0);
        check_val("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check_val("rst_m_tkeep",  64'(m_axis_tkeep),  64'd0);
        check_val("rst_arb_gnt",  64'(arb_gnt),       64'd0);
        check_val("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
        check_val("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
        check_val("rst_pkt_cnt_0", 64'(pkt_cnt_0), 64'd0);
        check_val("rst_pkt_cnt_1", 64'(pkt_cnt_1), 64'd0);
`endif
        @(negedge axis_aclk);
        @(negedge axis_aclk);
        axis_aresetn = 1'b1;
    endtask

    // One cycle: drive at negedge, check at negedge+1, advance the model.
    task automatic step();
        logic rdy0, rdy1, hs0, hs1, v0, v1;
        int pick;
        @(negedge axis_aclk);
        for (int p = 0; p < 2; p++) begin
            if (!src_have[p]) begin
                if (rem[p] == 0) rem[p] = int'($urandom_range(len_hi[p], len_lo[p]));
                src_data[p] = {$urandom, $urandom};
                src_keep[p] = KEEP_W'($urandom);
                src_last[p] = (rem[p] == 1);
                src_have[p] = 1'b1;
            end
            if (!src_v[p]) src_v[p] = port_en[p] && (int'($urandom_range(99, 0)) < pvalid);
        end
        drive_pins();
        m_axis_tready = (int'($urandom_range(99, 0)) < pready);
        #1;
        rdy0 = (own == 0) && (!exp_mv || m_axis_tready);
        rdy1 = (own == 1) && (!exp_mv || m_axis_tready);
        check_val("arb_gnt", 64'(arb_gnt), (own == 0) ? 64'd1 : (own == 1) ? 64'd2 : 64'd0);
        check_val("s0_tready", 64'(s0_axis_tready), 64'(rdy0));
        check_val("s1_tready", 64'(s1_axis_tready), 64'(rdy1));
        check_val("m_tvalid", 64'(m_axis_tvalid), 64'(exp_mv));
        if (exp_mv) begin
            check_val("m_tdata", m_axis_tdata, exp_md);
            check_val("m_tkeep", 64'(m_axis_tkeep), 64'(exp_mk));
            check_val("m_tlast", 64'(m_axis_tlast), 64'(exp_ml));
            check_val("m_tid",   64'(m_axis_tid),   64'(exp_mid));
        end
        if (m_axis_tvalid && m_axis_tready) obs_beats++;

        v0 = src_v[0]; v1 = src_v[1];
        hs0 = v0 && rdy0;
        hs1 = v1 && rdy1;
        if (hs0 || hs1) begin
            pick = hs0 ? 0 : 1;
            exp_mv = 1'b1; exp_md = src_data[pick]; exp_mk = src_keep[pick];
            exp_ml = src_last[pick]; exp_mid = pick[0];
        end else if (m_axis_tready) begin
            exp_mv = 1'b0;
        end
        if (own < 0) begin
            pick = (v0 && v1) ? (last_g ? 0 : 1) : v0 ? 0 : v1 ? 1 : -1;
            if (pick >= 0) begin
                own = pick; last_g = pick[0];
                grant_log.push_back(pick);
            end
        end else if ((own == 0 && hs0 && src_last[0]) || (own == 1 && hs1 && src_last[1])) begin
            own = -1;
        end
        for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? hs0 : hs1) begin
                if (src_last[p]) exp_pkts[p]++;
                acc_beats[p]++;
                rem[p]--;
                src_have[p] = 1'b0;
                src_v[p] = 1'b0;
            end
        end
    endtask

    task automatic set_mode(input logic en0, input int lo0, input int hi0,
                            input logic en1, input int lo1, input int hi1,
                            input int pv, input int pr);
        port_en[0] = en0; len_lo[0] = lo0; len_hi[0] = hi0;
        port_en[1] = en1; len_lo[1] = lo1; len_hi[1] = hi1;
        pvalid = pv; pready = pr;
    endtask

    initial begin
        int bound;
        for (int p = 0; p < 2; p++) begin
            src_data[p] = '0; src_keep[p] = '0; src_last[p] = 1'b0;
        end
        obs_beats = 0;
        set_mode(1'b0, 1, 1, 1'b0, 1, 1, 100, 100);
        do_reset();

        // both ports saturated with 2-beat packets: tie order 0,1,0,1
        set_mode(1'b1, 2, 2, 1'b1, 2, 2, 100, 100);
        for (int i = 0; i < 24; i++) step();
        check_val("gnt_log_len", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check_val("gnt_order", 64'(grant_log[i]), 64'(i % 2));
        end

        // random traffic with backpressure and mid-packet valid gaps
        set_mode(1'b1, 1, 5, 1'b1, 1, 5, 70, 60);
        for (int i = 0; i < 2500; i++) step();
        set_mode(1'b1, 1, 8, 1'b1, 1, 3, 90, 30);
        for (int i = 0; i < 1500; i++) step();
`ifdef AXIS_ARB_PKT_CNT_EN
        check_val("pkt_cnt_0", 64'(pkt_cnt_0), 64'(exp_pkts[0]));
        check_val("pkt_cnt_1", 64'(pkt_cnt_1), 64'(exp_pkts[1]));
`endif

        // back-to-back single-beat packets from port 1: one beat every 2 cycles
        set_mode(1'b0, 1, 1, 1'b1, 1, 1, 100, 100);
        do_reset();
        obs_beats = 0;
        for (int i = 0; i < 40; i++) step();
        check_val("single_beat_rate", 64'(obs_beats), 64'd19);

        // reset during beat 3 of a 6-beat port-0 packet, then port 0 again
        set_mode(1'b1, 6, 6, 1'b0, 1, 1, 100, 100);
        do_reset();
        bound = 0;
        while (acc_beats[0] < 2 && bound < 50) begin
            step();
            bound++;
        end
        check_val("midpkt_reach_beat3", 64'(acc_beats[0]), 64'd2);
        do_reset();
        set_mode(1'b1, 1, 6, 1'b0, 1, 1, 80, 70);
        for (int i = 0; i < 300; i++) step();
        check_val("post_rst_pkts", 64'(exp_pkts[0] > 0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
